hub75_panel_rx: RTL and testbench

//  Panel-side receiver for the HUB75 LED matrix interface (RGB1/RGB2, A-D row, LAT, OE).

---
 rtl/hub75_panel_rx.sv | 149 ++++++++++++++
 tb/tb_hub75_panel_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_panel_rx
//  Description : HUB75 panel-side receiver. Samples the shifted RGB stream,
//                captures a row pair on each LAT rising edge and replays it
//                as a column-indexed, ready/valid pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_panel_rx #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             shift_en,
  input  logic [2:0]                       rgb1_in,
  input  logic [2:0]                       rgb2_in,
  input  logic [ROW_BITS-1:0]              row_in,
  input  logic                             lat_in,
  input  logic                             oe_in,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [ROW_BITS-1:0]              pix_row,
  output logic [$clog2(COLS)-1:0]          pix_col,
  output logic [2:0]                       pix_rgb1,
  output logic [2:0]                       pix_rgb2,
  output logic                             pix_last,
  output logic                             pix_shown,
  output logic                             row_err,
  output logic                             overrun
);

  localparam int CW   = $clog2(COLS);
  localparam int CNTW = $clog2(2 * COLS);

  localparam logic [CW-1:0]   c_col_last = CW'(COLS - 1);
  localparam logic [CNTW-1:0] c_cnt_max  = CNTW'(2 * COLS - 1);
  localparam logic [CNTW-1:0] c_cnt_full = CNTW'(COLS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t               r_state;
  logic [2:0]           r_sr1   [COLS];
  logic [2:0]           r_sr2   [COLS];
  logic [2:0]           r_hold1 [COLS];
  logic [2:0]           r_hold2 [COLS];
  logic [CNTW-1:0]      r_shift_cnt;
  logic                 r_lat_d;
  logic                 r_valid;
  logic [CW-1:0]        r_col;
  logic [ROW_BITS-1:0]  r_row;
  logic                 r_shown;
  logic                 r_row_err;
  logic                 r_overrun;

  logic [2:0]           w_sr1_nxt [COLS];
  logic [2:0]           w_sr2_nxt [COLS];
  logic [CNTW-1:0]      w_cnt_eff;
  logic                 w_latch;

  // Shift register after this edge's sample; a latch on the same edge sees it.
  always_comb begin
    w_sr1_nxt = r_sr1;
    w_sr2_nxt = r_sr2;
    if (shift_en) begin
      for (int i = 0; i < COLS - 1; i++) begin
        w_sr1_nxt[i] = r_sr1[i+1];
        w_sr2_nxt[i] = r_sr2[i+1];
      end
      w_sr1_nxt[COLS-1] = rgb1_in;
      w_sr2_nxt[COLS-1] = rgb2_in;
    end
  end

  assign w_latch   = lat_in & ~r_lat_d;
  assign w_cnt_eff = (shift_en && (r_shift_cnt != c_cnt_max)) ? r_shift_cnt + 1'b1
                                                             : r_shift_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_lat_d     <= 1'b0;
      r_valid     <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_shown     <= 1'b0;
      r_row_err   <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        r_sr1[i]   <= '0;
        r_sr2[i]   <= '0;
        r_hold1[i] <= '0;
        r_hold2[i] <= '0;
      end
    end else begin
      r_lat_d   <= lat_in;
      r_row_err <= 1'b0;
      r_overrun <= 1'b0;
      r_sr1     <= w_sr1_nxt;
      r_sr2     <= w_sr2_nxt;

      if (w_latch) begin
        r_shift_cnt <= '0;
        r_row_err   <= (w_cnt_eff != c_cnt_full);
      end else begin
        r_shift_cnt <= w_cnt_eff;
      end

      if (!oe_in) r_shown <= 1'b1;

      if (r_state == S_IDLE) begin
        if (w_latch) begin
          r_hold1 <= w_sr1_nxt;
          r_hold2 <= w_sr2_nxt;
          r_row   <= row_in;
          r_shown <= 1'b0;
          r_col   <= '0;
          r_valid <= 1'b1;
          r_state <= S_DRAIN;
        end
      end else begin
        // A latch during replay is dropped; only the overrun flag records it.
        if (w_latch) r_overrun <= 1'b1;
        if (pix_ready) begin
          if (r_col == c_col_last) begin
            r_col   <= '0;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

  assign pix_valid = r_valid;
  assign pix_row   = r_row;
  assign pix_col   = r_col;
  assign pix_rgb1  = r_valid ? r_hold1[r_col] : 3'b000;
  assign pix_rgb2  = r_valid ? r_hold2[r_col] : 3'b000;
  assign pix_last  = r_valid && (r_col == c_col_last);
  assign pix_shown = r_shown;
  assign row_err   = r_row_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hub75_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_panel_rx
//  Description : Directed self-checking bench for hub75_panel_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_panel_rx;

  localparam int COLS     = 32;
  localparam int ROW_BITS = 4;
  localparam int CW       = 5;

  logic                clk;
  logic                reset;
  logic                shift_en;
  logic [2:0]          rgb1_in;
  logic [2:0]          rgb2_in;
  logic [ROW_BITS-1:0] row_in;
  logic                lat_in;
  logic                oe_in;
  logic                pix_valid;
  logic                pix_ready;
  logic [ROW_BITS-1:0] pix_row;
  logic [CW-1:0]       pix_col;
  logic [2:0]          pix_rgb1;
  logic [2:0]          pix_rgb2;
  logic                pix_last;
  logic                pix_shown;
  logic                row_err;
  logic                overrun;

  hub75_panel_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .rgb1_in   (rgb1_in),
    .rgb2_in   (rgb2_in),
    .row_in    (row_in),
    .lat_in    (lat_in),
    .oe_in     (oe_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_rgb1  (pix_rgb1),
    .pix_rgb2  (pix_rgb2),
    .pix_last  (pix_last),
    .pix_shown (pix_shown),
    .row_err   (row_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_pulses = 0;
  int n_ovr_pulses = 0;

  always @(posedge clk) begin
    if (row_err) n_err_pulses++;
    if (overrun) n_ovr_pulses++;
  end

  // Reference model: last COLS samples, shifts since last latch, captured row.
  logic [2:0]          m1 [$];
  logic [2:0]          m2 [$];
  int                  m_cnt;
  logic [2:0]          exp1 [COLS];
  logic [2:0]          exp2 [COLS];
  logic [ROW_BITS-1:0] exp_row;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m1.delete();
    m2.delete();
    for (int i = 0; i < COLS; i++) begin
      m1.push_back(3'b000);
      m2.push_back(3'b000);
    end
    m_cnt = 0;
  endtask

  task automatic model_shift(input logic [5:0] px);
    m1.push_back(px[5:3]);
    m2.push_back(px[2:0]);
    void'(m1.pop_front());
    void'(m2.pop_front());
    m_cnt++;
  endtask

  function automatic logic [5:0] pat(input int mode, input int k);
    case (mode)
      0:       return {3'(k % 8), 3'((~k) & 7)};
      1:       return {3'((k + 1) % 8), 3'((k * 3) % 8)};
      2:       return {3'((k + 2) % 8), 3'((k * 5 + 2) % 8)};
      3:       return {3'((k * 3) % 8), 3'((k * 5 + 1) % 8)};
      default: return {3'((k * 7) % 8), 3'(k % 5)};
    endcase
  endfunction

  task automatic shift_pix(input logic [5:0] px);
    @(negedge clk);
    shift_en = 1'b1;
    rgb1_in  = px[5:3];
    rgb2_in  = px[2:0];
    model_shift(px);
  endtask

  task automatic shift_row(input int n, input int mode);
    for (int k = 0; k < n; k++) shift_pix(pat(mode, k));
  endtask

  // Raise LAT (left high; drain drops it), optionally with a same-edge shift.
  task automatic pulse_lat(input logic [ROW_BITS-1:0] row, input bit cap,
                           input bit with_shift, input logic [5:0] px);
    logic exp_err;
    @(negedge clk);
    shift_en = with_shift;
    rgb1_in  = px[5:3];
    rgb2_in  = px[2:0];
    row_in   = row;
    lat_in   = 1'b1;
    if (with_shift) model_shift(px);
    exp_err = (m_cnt != COLS);
    m_cnt   = 0;
    if (cap) begin
      for (int i = 0; i < COLS; i++) begin
        exp1[i] = m1[i];
        exp2[i] = m2[i];
      end
      exp_row = row;
    end
    @(negedge clk);
    shift_en = 1'b0;
    check_eq("latch_flags", {30'd0, row_err, overrun}, {30'd0, exp_err, !cap});
    check_eq("latch_valid", {31'd0, pix_valid}, 32'd1);
  endtask

  // Replay from start_col until stop_col is on the bus; mode 1 stalls with 1,0,0,1.
  task automatic drain(input int start_col, input int stop_col, input int mode);
    int col = start_col;
    int cyc = 0;
    logic [3:0] rpat = 4'b1001;
    logic [31:0] got;
    logic [31:0] exp;
    while (col < stop_col && cyc < 400) begin
      if (cyc >= 2) lat_in = 1'b0;
      pix_ready = (mode == 1) ? rpat[3 - (cyc % 4)] : 1'b1;
      got = {15'd0, pix_valid, pix_row, pix_col, pix_rgb1, pix_rgb2, pix_last};
      exp = {15'd0, 1'b1, exp_row, CW'(col), exp1[col], exp2[col], (col == COLS - 1)};
      check_eq($sformatf("beat_c%0d", col), got, exp);
      if (pix_ready) col++;
      @(negedge clk);
      cyc++;
    end
    lat_in    = 1'b0;
    pix_ready = 1'b0;
    if (col < stop_col) check_eq("drain_timeout", 32'(col), 32'(stop_col));
    if (stop_col == COLS) check_eq("valid_after_last", {31'd0, pix_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {14'd0, pix_valid, pix_row, pix_col, pix_rgb1, pix_rgb2,
                   pix_last, pix_shown, row_err, overrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; shift_en = 1'b0; rgb1_in = '0; rgb2_in = '0;
    row_in = '0; lat_in = 1'b0; oe_in = 1'b1; pix_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // Basic row, OE blanked throughout
    row_in = 4'd5;
    shift_row(32, 0);
    pulse_lat(4'd5, 1'b1, 1'b0, 6'd0);
    drain(0, COLS, 0);
    check_eq("shown_blanked", {31'd0, pix_shown}, 32'd0);

    // Driver-style rows 1 and 2: blanked while shifting, displayed while replaying
    for (int r = 1; r <= 2; r++) begin
      oe_in = 1'b1;
      shift_row(32, r);
      pulse_lat(4'(r), 1'b1, 1'b0, 6'd0);
      oe_in = 1'b0;
      drain(0, COLS, 0);
      check_eq($sformatf("shown_row%0d", r), {31'd0, pix_shown}, 32'd1);
    end
    oe_in = 1'b1;

    // Short row (31) and long row (33); model supplies the window contents
    shift_row(31, 3);
    pulse_lat(4'd8, 1'b1, 1'b0, 6'd0);
    check_eq("shown_cleared", {31'd0, pix_shown}, 32'd0);
    drain(0, COLS, 0);
    shift_row(33, 4);
    pulse_lat(4'd9, 1'b1, 1'b0, 6'd0);
    check_eq("long_col0_second", {26'd0, exp1[0], exp2[0]}, {26'd0, pat(4, 1)});
    drain(0, COLS, 0);

    // 31 shifts plus one on the latch edge, replay with ready 1,0,0,1
    shift_row(31, 3);
    pulse_lat(4'd10, 1'b1, 1'b1, pat(3, 31));
    drain(0, COLS, 1);

    // Overrun: second LAT at col 10 while stalled
    shift_row(32, 4);
    pulse_lat(4'd3, 1'b1, 1'b0, 6'd0);
    drain(0, 10, 0);
    shift_row(32, 0);
    pulse_lat(4'd6, 1'b0, 1'b0, 6'd0);
    check_eq("overrun_col_held", {27'd0, pix_col}, 32'd10);
    drain(10, COLS, 0);

    // Reset in the middle of a replay, then a fresh row
    shift_row(32, 0);
    pulse_lat(4'd12, 1'b1, 1'b0, 6'd0);
    drain(0, 7, 0);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_drain");
    reset = 1'b0;
    model_clear();
    shift_row(32, 2);
    pulse_lat(4'd7, 1'b1, 1'b0, 6'd0);
    drain(0, COLS, 0);

    repeat (2) @(negedge clk);
    check_eq("row_err_pulses", 32'(n_err_pulses), 32'd2);
    check_eq("overrun_pulses", 32'(n_ovr_pulses), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
